// File: rtl/window_shift_buffer.sv
// window_shift_buffer
// Parametrised tap delay line that presents TAPS consecutive samples in
// parallel, with valid/ready handshakes on both sides, fill tracking and a
// runtime stride that sets how many accepted samples separate two windows.
// Tap 0 holds the newest sample. Tap TAPS-1 holds the oldest sample.

module window_shift_buffer #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 3,
    parameter int CNT_W  = $clog2(TAPS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [CNT_W-1:0]       stride,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAPS*DATA_W-1:0] out_taps,
    output logic [CNT_W-1:0]       fill_cnt
);

    localparam logic [CNT_W-1:0] LP_TAPS    = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] LP_TAPS_M1 = CNT_W'(TAPS - 1);

    logic [DATA_W-1:0] r_taps [TAPS];
    logic [CNT_W-1:0]  r_fill;
    logic [CNT_W-1:0]  r_gap;
    logic              r_out_valid;

    logic              w_acc;
    logic              w_full;
    logic              w_emit;
    logic [CNT_W-1:0]  w_stride_eff;
    logic [CNT_W:0]    w_gap_inc;
    logic [CNT_W:0]    w_stride_ext;
    logic [CNT_W-1:0]  w_gap_next;

    // The input side stalls only while an unconsumed window is held, so a
    // consumer that is ready lets the next sample through in the same cycle.
    assign in_ready     = ~clr & (~r_out_valid | out_ready);
    assign w_acc        = in_valid & in_ready;
    assign w_full       = (r_fill == LP_TAPS);
    assign w_stride_eff = (stride == '0) ? CNT_W'(1) : stride;
    assign w_gap_inc    = {1'b0, r_gap} + (CNT_W + 1)'(1);
    assign w_stride_ext = {1'b0, w_stride_eff};

    // Decide whether this accepted shift completes a window and advance the
    // gap counter. A stride lowered below the running gap restarts the count.
    always_comb begin
        w_emit     = 1'b0;
        w_gap_next = r_gap;
        if (w_acc) begin
            if (!w_full) begin
                w_gap_next = '0;
                if (r_fill == LP_TAPS_M1) begin
                    w_emit = 1'b1;
                end
            end else if (w_gap_inc == w_stride_ext) begin
                w_emit     = 1'b1;
                w_gap_next = '0;
            end else if (w_gap_inc > w_stride_ext) begin
                w_gap_next = '0;
            end else begin
                w_gap_next = w_gap_inc[CNT_W-1:0];
            end
        end
    end

    // Shift register of samples: newest enters at tap 0 on every accept.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            for (int k = 0; k < TAPS; k++) begin
                r_taps[k] <= '0;
            end
        end else if (w_acc) begin
            r_taps[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
                r_taps[k] <= r_taps[k-1];
            end
        end
    end

    // Fill count saturates once every tap holds a real sample.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            r_fill <= '0;
        end else if (w_acc && !w_full) begin
            r_fill <= r_fill + CNT_W'(1);
        end
    end

    // Gap counter register, next value decided above.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            r_gap <= '0;
        end else begin
            r_gap <= w_gap_next;
        end
    end

    // Window-valid flag: a fresh emit beats a consume in the same cycle.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            r_out_valid <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Flatten the tap array onto the parallel output bus.
    always_comb begin
        out_taps = '0;
        for (int k = 0; k < TAPS; k++) begin
            out_taps[k*DATA_W +: DATA_W] = r_taps[k];
        end
    end

    assign out_valid = r_out_valid;
    assign fill_cnt  = r_fill;

endmodule

// File: tb/tb_window_shift_buffer.sv
// Testbench for window_shift_buffer.
// Instance A (TAPS=3, DATA_W=8) runs directed scenarios with known windows.
// Instance B (TAPS=5, DATA_W=12) runs a randomized soak against a queue model.

module tb_window_shift_buffer;

    localparam int B_TAPS = 5;
    localparam int B_W    = 12;
    localparam int B_CW   = 3;

    logic clk;
    int   checkCount = 0;
    int   failCount  = 0;

    logic        aRst, aClr, aInValid, aInReady, aOutValid, aOutReady;
    logic [1:0]  aStride, aFill;
    logic [7:0]  aInData;
    logic [23:0] aOutTaps;

    logic                  bRst, bClr, bInValid, bInReady, bOutValid, bOutReady;
    logic [B_CW-1:0]       bStride, bFill;
    logic [B_W-1:0]        bInData;
    logic [B_TAPS*B_W-1:0] bOutTaps;

    window_shift_buffer #(.DATA_W(8), .TAPS(3)) dutA (
        .clk(clk), .rst(aRst), .clr(aClr), .stride(aStride),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady),
        .out_taps(aOutTaps), .fill_cnt(aFill)
    );

    window_shift_buffer #(.DATA_W(B_W), .TAPS(B_TAPS)) dutB (
        .clk(clk), .rst(bRst), .clr(bClr), .stride(bStride),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .out_valid(bOutValid), .out_ready(bOutReady),
        .out_taps(bOutTaps), .fill_cnt(bFill)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        aInValid  = v;
        aInData   = d;
        aOutReady = r;
        tick();
    endtask

    task automatic clearA();
        aClr = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        aClr = 1'b0;
    endtask

    // Soak model state: history of accepted samples, newest first.
    logic [B_W-1:0]        hist[$];
    logic [B_TAPS*B_W-1:0] expTaps;
    int  mFill, since, s, accepted, windows;
    bit  mValid, mReady, emit, expEmit;

    initial begin
        aRst = 1'b1; aClr = 1'b0; aStride = 2'd1; aInValid = 1'b1; aInData = 8'h55; aOutReady = 1'b1;
        bRst = 1'b1; bClr = 1'b0; bStride = 3'd1; bInValid = 1'b0; bInData = '0;   bOutReady = 1'b1;

        // Reset held for two cycles with a sample offered: nothing is taken.
        tick();
        tick();
        checkOutput("reset_taps", 64'(aOutTaps), 64'h0);
        checkOutput("reset_valid", 64'(aOutValid), 64'h0);
        checkOutput("reset_fill", 64'(aFill), 64'h0);
        aRst = 1'b0;
        aInValid = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(aInReady), 64'h1);

        // Fill with stride 1.
        applyStimulus(1'b1, 8'h11, 1'b1);
        checkOutput("fill_valid_1", 64'(aOutValid), 64'h0);
        checkOutput("fill_cnt_1", 64'(aFill), 64'h1);
        applyStimulus(1'b1, 8'h22, 1'b1);
        checkOutput("fill_valid_2", 64'(aOutValid), 64'h0);
        applyStimulus(1'b1, 8'h33, 1'b1);
        checkOutput("fill_valid_3", 64'(aOutValid), 64'h1);
        checkOutput("fill_taps_3", 64'(aOutTaps), 64'h112233);
        applyStimulus(1'b1, 8'h44, 1'b1);
        checkOutput("fill_valid_4", 64'(aOutValid), 64'h1);
        checkOutput("fill_taps_4", 64'(aOutTaps), 64'h223344);
        checkOutput("fill_cnt_sat", 64'(aFill), 64'h3);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fill_consumed", 64'(aOutValid), 64'h0);

        // Stride 2: windows after samples 3, 5 and 7.
        clearA();
        aStride = 2'd2;
        windows = 0;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1);
            expEmit = (i == 3) || (i == 5) || (i == 7);
            checkOutput($sformatf("stride2_valid_%0d", i), 64'(aOutValid), 64'(expEmit));
            if (aOutValid) begin
                windows++;
                checkOutput($sformatf("stride2_t0_%0d", i), 64'(aOutTaps[7:0]), 64'(i));
            end
        end
        checkOutput("stride2_windows", 64'(windows), 64'd3);

        // Stride 0 behaves like stride 1.
        clearA();
        aStride = 2'd0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1);
            checkOutput($sformatf("stride0_valid_%0d", i), 64'(aOutValid), 64'(i >= 3));
        end

        // Backpressure: window held, next sample waits, then goes in with the consume.
        clearA();
        aStride = 2'd1;
        applyStimulus(1'b1, 8'h11, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b1);
        aInValid = 1'b1; aInData = 8'h44; aOutReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp_in_ready_%0d", i), 64'(aInReady), 64'h0);
            tick();
            checkOutput($sformatf("bp_taps_%0d", i), 64'(aOutTaps), 64'h112233);
            checkOutput($sformatf("bp_valid_%0d", i), 64'(aOutValid), 64'h1);
        end
        aOutReady = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(aInReady), 64'h1);
        tick();
        checkOutput("bp_release_valid", 64'(aOutValid), 64'h1);
        checkOutput("bp_release_taps", 64'(aOutTaps), 64'h223344);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("bp_drain_valid", 64'(aOutValid), 64'h0);
        checkOutput("bp_drain_taps", 64'(aOutTaps), 64'h223344);

        // Clear mid-fill with a sample offered.
        clearA();
        applyStimulus(1'b1, 8'hA1, 1'b1);
        applyStimulus(1'b1, 8'hA2, 1'b1);
        aClr = 1'b1; aInValid = 1'b1; aInData = 8'hA3;
        #1;
        checkOutput("clr_in_ready", 64'(aInReady), 64'h0);
        tick();
        aClr = 1'b0;
        checkOutput("clr_fill", 64'(aFill), 64'h0);
        checkOutput("clr_taps", 64'(aOutTaps), 64'h0);
        checkOutput("clr_valid", 64'(aOutValid), 64'h0);
        applyStimulus(1'b1, 8'hB1, 1'b1);
        checkOutput("clr_refill_1", 64'(aOutValid), 64'h0);
        applyStimulus(1'b1, 8'hB2, 1'b1);
        checkOutput("clr_refill_2", 64'(aOutValid), 64'h0);
        applyStimulus(1'b1, 8'hB3, 1'b1);
        checkOutput("clr_refill_3", 64'(aOutValid), 64'h1);
        checkOutput("clr_refill_taps", 64'(aOutTaps), 64'hB1B2B3);
        aInValid = 1'b0;

        // Randomized soak on the deeper, wider instance.
        bRst = 1'b0;
        tick();
        hist.delete();
        mFill = 0; since = 0; mValid = 1'b0; accepted = 0;
        for (int cyc = 0; cyc < 30000 && accepted < 10000; cyc++) begin
            bInValid  = ($urandom_range(0, 3) != 0);
            bInData   = B_W'($urandom);
            bOutReady = ($urandom_range(0, 3) != 0);
            bClr      = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) bStride = B_CW'($urandom_range(0, 4));
            #1;
            mReady = !bClr && (!mValid || bOutReady);
            checkOutput("soak_in_ready", 64'(bInReady), 64'(mReady));
            tick();

            s = (bStride == 0) ? 1 : int'(bStride);
            emit = 1'b0;
            if (bClr) begin
                hist.delete();
                mFill = 0; since = 0; mValid = 1'b0;
            end else begin
                if (bInValid && mReady) begin
                    accepted++;
                    hist.push_front(bInData);
                    if (hist.size() > B_TAPS) void'(hist.pop_back());
                    if (mFill < B_TAPS) begin
                        mFill++;
                        since = 0;
                        emit = (mFill == B_TAPS);
                    end else begin
                        since++;
                        if (since == s) begin
                            emit = 1'b1;
                            since = 0;
                        end else if (since > s) begin
                            since = 0;
                        end
                    end
                end
                if (emit) mValid = 1'b1;
                else if (mValid && bOutReady) mValid = 1'b0;
            end
            expTaps = '0;
            for (int k = 0; k < hist.size(); k++) expTaps[k*B_W +: B_W] = hist[k];

            checkOutput("soak_valid", 64'(bOutValid), 64'(mValid));
            checkOutput("soak_taps", 64'(bOutTaps), 64'(expTaps));
            checkOutput("soak_fill", 64'(bFill), 64'(mFill));
        end
        checkOutput("soak_sample_count", 64'(accepted >= 10000), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
